// File: rtl/multibank_input_sram_interface.sv
`timescale 1ns/1ps
// Input-activation SRAM front end: ping-pong (or single) buffers of two
// DEPTH-word banks, a streaming load port, two compute read ports and a
// debug readback path that walks the active buffer for a serializer.
//
// Debug FSM
//   state   | meaning
//   ST_IDLE | debug low; R/O port serves compute reads (ren/radr)
//   ST_READ | debug readback; R/O port reads active buffer at debug pointer
module multibank_input_sram_interface #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_BUFFERS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  debug,
    input  logic                  debug_read_trig,
    input  logic                  swap,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] radr,
    input  logic                  rwen,
    input  logic [ADDR_WIDTH-1:0] rwadr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] rwdata,
    output logic                  active_buf,
    output logic                  load_done,
    output logic                  debug_done,
    output logic                  swap_err
);
    localparam int BUF_WORDS = 2 * DEPTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_WORDS - 1);
    localparam logic DOUBLE_BUF = (NUM_BUFFERS == 2);

    typedef enum logic {ST_IDLE, ST_READ} dbg_state_t;

    // Address MSB is the bank select, the remaining bits the word within the
    // bank, so the full address indexes the concatenated bank pair directly.
    // Buffer 1 is never written or read in single-buffer mode.
    logic [DATA_WIDTH-1:0] r_mem [0:1][0:BUF_WORDS-1];

    dbg_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_load_ptr;
    logic [ADDR_WIDTH-1:0] r_dbg_ptr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_rwdata;
    logic                  r_active;
    logic                  r_load_done;
    logic                  r_debug_done;
    logic                  r_swap_err;

    logic                  w_ld_buf;
    logic                  w_wr_en;
    logic                  w_ro_en;
    logic [ADDR_WIDTH-1:0] w_ro_adr;
    logic                  w_swap_ok;

    assign w_ld_buf  = DOUBLE_BUF ? ~r_active : 1'b0;
    assign w_wr_en   = load && wdata_valid;
    // Debug owns the R/O port whenever debug is high; the rising-edge cycle
    // issues nothing so that the first debug read lands in ST_READ.
    assign w_ro_en   = debug ? (r_state == ST_READ) : ren;
    assign w_ro_adr  = debug ? r_dbg_ptr : radr;
    assign w_swap_ok = swap && DOUBLE_BUF && !load && !debug;

    assign rdata      = r_rdata;
    assign rwdata     = r_rwdata;
    assign active_buf = r_active;
    assign load_done  = r_load_done;
    assign debug_done = r_debug_done;
    assign swap_err   = r_swap_err;

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_ld_buf][r_load_ptr] <= wdata_in;
        end
    end

    // Load pointer and end-of-buffer pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_ptr  <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_wr_en && (r_load_ptr == LAST_ADDR);
            if (!load) begin
                r_load_ptr <= '0;
            end else if (w_wr_en) begin
                r_load_ptr <= r_load_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Registered read ports on the active buffer; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rwdata <= '0;
        end else begin
            if (w_ro_en) begin
                r_rdata <= r_mem[r_active][w_ro_adr];
            end
            if (rwen) begin
                r_rwdata <= r_mem[r_active][rwadr];
            end
        end
    end

    // Debug readback FSM, pointer and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dbg_ptr    <= '0;
            r_debug_done <= 1'b0;
        end else begin
            r_debug_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (debug) begin
                        r_state   <= ST_READ;
                        r_dbg_ptr <= '0;
                    end
                end
                ST_READ: begin
                    if (!debug) begin
                        r_state   <= ST_IDLE;
                        r_dbg_ptr <= '0;
                    end else if (debug_read_trig) begin
                        r_dbg_ptr    <= r_dbg_ptr + ADDR_WIDTH'(1);
                        r_debug_done <= (r_dbg_ptr == LAST_ADDR);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer swap; a read issued alongside still sees the pre-swap buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_swap_err <= 1'b0;
        end else begin
            r_swap_err <= swap && !w_swap_ok;
            if (w_swap_ok) begin
                r_active <= ~r_active;
            end
        end
    end

endmodule

// File: tb/tb_multibank_input_sram_interface.sv
`timescale 1ns/1ps
// Directed bench: ping-pong loads, dual-port reads, debug readback, swap
// rejection, reset mid-load, plus a small single-buffer instance.
module tb_multibank_input_sram_interface;
    localparam int DW = 16;
    localparam int N  = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load, wdata_valid, debug, debug_read_trig, swap, ren, rwen;
    logic [DW-1:0] wdata_in;
    logic [11:0]   radr, rwadr;
    logic [DW-1:0] rdata, rwdata;
    logic          active_buf, load_done, debug_done, swap_err;

    logic          s_load, s_wdata_valid, s_debug, s_trig, s_swap, s_ren, s_rwen;
    logic [DW-1:0] s_wdata_in;
    logic [2:0]    s_radr, s_rwadr;
    logic [DW-1:0] s_rdata, s_rwdata;
    logic          s_active, s_load_done, s_debug_done, s_swap_err;

    int vecs = 0;
    int errs = 0;
    logic [DW-1:0] set_a [N];
    logic [DW-1:0] set_b [N];
    logic [DW-1:0] set_d [N];

    always #5 clk = ~clk;

    multibank_input_sram_interface dut (
        .clk(clk), .rst_n(rst_n), .load(load), .wdata_valid(wdata_valid),
        .wdata_in(wdata_in), .debug(debug), .debug_read_trig(debug_read_trig),
        .swap(swap), .ren(ren), .radr(radr), .rwen(rwen), .rwadr(rwadr),
        .rdata(rdata), .rwdata(rwdata), .active_buf(active_buf),
        .load_done(load_done), .debug_done(debug_done), .swap_err(swap_err)
    );

    multibank_input_sram_interface #(
        .DATA_WIDTH(16), .DEPTH(4), .ADDR_WIDTH(3), .NUM_BUFFERS(1)
    ) u_single (
        .clk(clk), .rst_n(rst_n), .load(s_load), .wdata_valid(s_wdata_valid),
        .wdata_in(s_wdata_in), .debug(s_debug), .debug_read_trig(s_trig),
        .swap(s_swap), .ren(s_ren), .radr(s_radr), .rwen(s_rwen), .rwadr(s_rwadr),
        .rdata(s_rdata), .rwdata(s_rwdata), .active_buf(s_active),
        .load_done(s_load_done), .debug_done(s_debug_done), .swap_err(s_swap_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words of a set into the shadow buffer; leaves load high.
    task automatic load_set(input int which, input int n, output int pulses, output int pulse_idx);
        pulses = 0;
        pulse_idx = -1;
        load = 1'b1;
        for (int i = 0; i < n; i++) begin
            wdata_valid = 1'b1;
            wdata_in = (which == 0) ? set_a[i] : (which == 1) ? set_b[i] : set_d[i];
            tick();
            if (load_done) begin pulses++; pulse_idx = i; end
        end
        wdata_valid = 1'b0;
        tick();
        if (load_done) pulses++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {load, wdata_valid, debug, debug_read_trig, swap, ren, rwen} = '0;
        wdata_in = '0; radr = '0; rwadr = '0;
        {s_load, s_wdata_valid, s_debug, s_trig, s_swap, s_ren, s_rwen} = '0;
        s_wdata_in = '0; s_radr = '0; s_rwadr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        vecs++; if (rdata !== 16'h0) begin errs++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        vecs++; if (rwdata !== 16'h0) begin errs++; $display("FAIL reset_rwdata got %h want 0000", rwdata); end
        vecs++; if (active_buf !== 1'b0) begin errs++; $display("FAIL reset_active got %b want 0", active_buf); end
        vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL reset_load_done got %b want 0", load_done); end
        vecs++; if (debug_done !== 1'b0) begin errs++; $display("FAIL reset_debug_done got %b want 0", debug_done); end
        vecs++; if (swap_err !== 1'b0) begin errs++; $display("FAIL reset_swap_err got %b want 0", swap_err); end
    endtask

    task automatic test_load_and_swap();
        int pulses, idx;
        load_set(0, N, pulses, idx);
        load = 1'b0;
        tick();
        vecs++; if (pulses !== 1) begin errs++; $display("FAIL load_a_pulses got %0d want 1", pulses); end
        vecs++; if (idx !== N - 1) begin errs++; $display("FAIL load_a_pulse_word got %0d want %0d", idx, N - 1); end
        swap = 1'b1;
        tick();
        swap = 1'b0;
        vecs++; if (active_buf !== 1'b1) begin errs++; $display("FAIL swap_toggle got %b want 1", active_buf); end
        vecs++; if (swap_err !== 1'b0) begin errs++; $display("FAIL swap_ok_err got %b want 0", swap_err); end
    endtask

    task automatic test_dual_port();
        for (int i = 0; i < N; i++) begin
            ren = 1'b1; radr = 12'(i);
            rwen = 1'b1; rwadr = 12'(N - 1 - i);
            tick();
            vecs++; if (rdata !== set_a[i]) begin errs++; $display("FAIL dual_rdata[%0d] got %h want %h", i, rdata, set_a[i]); end
            vecs++; if (rwdata !== set_a[N-1-i]) begin errs++; $display("FAIL dual_rwdata[%0d] got %h want %h", i, rwdata, set_a[N-1-i]); end
        end
        ren = 1'b0; rwen = 1'b0; radr = 12'd5; rwadr = 12'd6;
        repeat (2) tick();
        vecs++; if (rdata !== set_a[N-1]) begin errs++; $display("FAIL hold_rdata got %h want %h", rdata, set_a[N-1]); end
        vecs++; if (rwdata !== set_a[0]) begin errs++; $display("FAIL hold_rwdata got %h want %h", rwdata, set_a[0]); end
    endtask

    task automatic test_debug_readback();
        int dpulses = 0;
        ren = 1'b1; radr = 12'd7; rwen = 1'b1; rwadr = 12'd0;
        debug = 1'b1;
        tick();
        tick();
        vecs++; if (rdata !== set_a[0]) begin errs++; $display("FAIL dbg_first got %h want %h", rdata, set_a[0]); end
        for (int k = 1; k < N; k++) begin
            rwadr = 12'(k);
            debug_read_trig = 1'b1;
            tick();
            if (debug_done) dpulses++;
            debug_read_trig = 1'b0;
            tick();
            if (debug_done) dpulses++;
            vecs++; if (rdata !== set_a[k]) begin errs++; $display("FAIL dbg_rdata[%0d] got %h want %h", k, rdata, set_a[k]); end
            vecs++; if (rwdata !== set_a[k]) begin errs++; $display("FAIL dbg_rwdata[%0d] got %h want %h", k, rwdata, set_a[k]); end
        end
        vecs++; if (dpulses !== 0) begin errs++; $display("FAIL dbg_early_done got %0d want 0", dpulses); end
        debug_read_trig = 1'b1;
        tick();
        debug_read_trig = 1'b0;
        vecs++; if (debug_done !== 1'b1) begin errs++; $display("FAIL dbg_done got %b want 1", debug_done); end
        tick();
        vecs++; if (debug_done !== 1'b0) begin errs++; $display("FAIL dbg_done_width got %b want 0", debug_done); end
        vecs++; if (rdata !== set_a[0]) begin errs++; $display("FAIL dbg_wrap got %h want %h", rdata, set_a[0]); end
        swap = 1'b1;
        tick();
        swap = 1'b0;
        vecs++; if (swap_err !== 1'b1) begin errs++; $display("FAIL swap_dbg_err got %b want 1", swap_err); end
        vecs++; if (active_buf !== 1'b1) begin errs++; $display("FAIL swap_dbg_active got %b want 1", active_buf); end
        tick();
        vecs++; if (swap_err !== 1'b0) begin errs++; $display("FAIL swap_err_width got %b want 0", swap_err); end
        debug = 1'b0; ren = 1'b0; rwen = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_pingpong();
        int pulses = 0, idx = -1;
        int pick [6] = '{0, 1, 2047, 2048, 4095, 1234};
        load = 1'b1; swap = 1'b1;
        tick();
        swap = 1'b0;
        vecs++; if (swap_err !== 1'b1) begin errs++; $display("FAIL swap_load_err got %b want 1", swap_err); end
        vecs++; if (active_buf !== 1'b1) begin errs++; $display("FAIL swap_load_active got %b want 1", active_buf); end
        for (int i = 0; i < N; i++) begin
            wdata_valid = 1'b1; wdata_in = set_b[i];
            ren = 1'b1; radr = 12'(i);
            tick();
            if (load_done) begin pulses++; idx = i; end
            vecs++; if (rdata !== set_a[i]) begin errs++; $display("FAIL pp_read_a[%0d] got %h want %h", i, rdata, set_a[i]); end
        end
        wdata_valid = 1'b0; ren = 1'b0; load = 1'b0;
        tick();
        vecs++; if (pulses !== 1 || idx !== N - 1) begin errs++; $display("FAIL load_b_done got %0d@%0d want 1@%0d", pulses, idx, N - 1); end
        swap = 1'b1; ren = 1'b1; radr = 12'd3;
        tick();
        swap = 1'b0; ren = 1'b0;
        vecs++; if (rdata !== set_a[3]) begin errs++; $display("FAIL swap_same_cycle got %h want %h", rdata, set_a[3]); end
        vecs++; if (active_buf !== 1'b0) begin errs++; $display("FAIL swap_back got %b want 0", active_buf); end
        for (int j = 0; j < 6; j++) begin
            ren = 1'b1; radr = 12'(pick[j]);
            rwen = 1'b1; rwadr = (j == 5) ? 12'(pick[j]) : 12'(N - 1 - pick[j]);
            tick();
            vecs++; if (rdata !== set_b[pick[j]]) begin errs++; $display("FAIL pp_rdata_b[%0d] got %h want %h", pick[j], rdata, set_b[pick[j]]); end
            vecs++; if (rwdata !== set_b[rwadr]) begin errs++; $display("FAIL pp_rwdata_b[%0d] got %h want %h", rwadr, rwdata, set_b[rwadr]); end
        end
        ren = 1'b0; rwen = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload();
        int pulses, idx;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        load_set(2, 100, pulses, idx);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (active_buf !== 1'b0) begin errs++; $display("FAIL async_active got %b want 0", active_buf); end
        vecs++; if (rdata !== 16'h0) begin errs++; $display("FAIL async_rdata got %h want 0000", rdata); end
        vecs++; if (pulses !== 0) begin errs++; $display("FAIL partial_done got %0d want 0", pulses); end
        tick();
        vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL reset_no_pulse got %b want 0", load_done); end
        rst_n = 1'b1;
        ren = 1'b1; radr = 12'd5; rwen = 1'b1; rwadr = 12'd200;
        tick();
        ren = 1'b0; rwen = 1'b0;
        vecs++; if (rdata !== set_d[5]) begin errs++; $display("FAIL retain_new got %h want %h", rdata, set_d[5]); end
        vecs++; if (rwdata !== set_b[200]) begin errs++; $display("FAIL retain_old got %h want %h", rwdata, set_b[200]); end
        load_set(2, N, pulses, idx);
        load = 1'b0;
        vecs++; if (pulses !== 1 || idx !== N - 1) begin errs++; $display("FAIL reload_done got %0d@%0d want 1@%0d", pulses, idx, N - 1); end
        swap = 1'b1;
        tick();
        swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            ren = 1'b1; radr = 12'(i);
            tick();
            vecs++; if (rdata !== set_d[i]) begin errs++; $display("FAIL reload_read[%0d] got %h want %h", i, rdata, set_d[i]); end
        end
        ren = 1'b0;
        tick();
    endtask

    task automatic test_single_buffer();
        int pulses = 0, idx = -1;
        s_load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_wdata_valid = 1'b1; s_wdata_in = 16'hA000 + 16'(i);
            tick();
            if (s_load_done) begin pulses++; idx = i; end
        end
        s_load = 1'b0; s_wdata_in = 16'hBEEF;
        repeat (2) tick();
        s_wdata_valid = 1'b0;
        vecs++; if (pulses !== 1 || idx !== 7) begin errs++; $display("FAIL single_done got %0d@%0d want 1@7", pulses, idx); end
        s_swap = 1'b1;
        tick();
        s_swap = 1'b0;
        vecs++; if (s_swap_err !== 1'b1) begin errs++; $display("FAIL single_swap_err got %b want 1", s_swap_err); end
        vecs++; if (s_active !== 1'b0) begin errs++; $display("FAIL single_active got %b want 0", s_active); end
        s_ren = 1'b1; s_radr = 3'd5; s_rwen = 1'b1; s_rwadr = 3'd0;
        tick();
        s_ren = 1'b0; s_rwen = 1'b0;
        vecs++; if (s_rdata !== 16'hA005) begin errs++; $display("FAIL single_rdata got %h want a005", s_rdata); end
        vecs++; if (s_rwdata !== 16'hA000) begin errs++; $display("FAIL single_rwdata got %h want a000", s_rwdata); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            set_a[i] = 16'($urandom);
            set_b[i] = 16'($urandom);
            set_d[i] = 16'($urandom);
        end
        test_reset();
        test_load_and_swap();
        test_dual_port();
        test_debug_readback();
        test_pingpong();
        test_reset_midload();
        test_single_buffer();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
